// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, derived sync windows and a range helper
// shared by the VGA driver.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF  = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  localparam int COLOUR_W     = 8;

  // Half-open window test on a raster counter: lo <= x < hi.
  function automatic logic in_range(logic [9:0] x, logic [9:0] lo, logic [9:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Free-running system-clock divider; pix_tick_o is high on the last clock of
// every CLK_DIV-clock pixel period.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pix_tick_o
);

  localparam int             W    = $clog2(CLK_DIV);
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q, div_d;

  assign pix_tick_o = (div_q == LAST);

  always_comb begin
    div_d = pix_tick_o ? '0 : div_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_interface.sv
// VGA raster driver: pixel address out to the game logic, colour and sync to the
// pins one pixel period later, plus a per-frame strobe.
module vga_interface
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [COLOUR_W-1:0] COLOUR_IN,
  output logic [9:0]          ADDRH,
  output logic [8:0]          ADDRV,
  output logic                HS,
  output logic                VS,
  output logic [COLOUR_W-1:0] COLOUR_OUT,
  output logic                FRAME_TICK
);

  localparam int         H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic                pix_tick;
  logic [9:0]          h_cnt_q, h_cnt_d;
  logic [9:0]          v_cnt_q, v_cnt_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                active, h_wrap, v_wrap;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .pix_tick_o (pix_tick)
  );

  assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  // Output stage decodes the pre-increment position so colour and sync for a
  // pixel land on the same tick.
  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    colour_d = colour_q;
    if (pix_tick) begin
      h_cnt_d  = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      hs_d     = !in_range(h_cnt_q, HS_LO, HS_HI);
      vs_d     = !in_range(v_cnt_q, VS_LO, VS_HI);
      colour_d = active ? COLOUR_IN : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= '0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
    end
  end

  assign ADDRH      = active ? h_cnt_q : '0;
  assign ADDRV      = active ? v_cnt_q[8:0] : '0;
  assign HS         = hs_q;
  assign VS         = vs_q;
  assign COLOUR_OUT = colour_q;
  // Gated by RESET so a reset landing on the wrap tick produces no strobe.
  assign FRAME_TICK = pix_tick && h_wrap && v_wrap && !RESET;

endmodule

// File: tb/tb_vga_interface.sv
// Bench: a shrunken raster checked every clock against a time-indexed model, plus
// literal timing checks on a full 640x480 instance.
module tb_vga_interface;

  localparam int D   = 3;
  localparam int HA  = 16, HF = 2, HSY = 4, HB = 3, HT = HA + HF + HSY + HB;
  localparam int VA  = 6,  VF = 1, VSY = 2, VB = 2, VT = VA + VF + VSY + VB;
  localparam int FR  = HT * VT;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] col_s = 8'h00, col_b = 8'h00;

  logic [9:0] addrh_s, addrh_b;
  logic [8:0] addrv_s, addrv_b;
  logic       hs_s, vs_s, ft_s, hs_b, vs_b, ft_b;
  logic [7:0] colo_s, colo_b;

  always #5 CLK = ~CLK;

  vga_interface #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut_s (
    .CLK(CLK), .RESET(RESET), .COLOUR_IN(col_s), .ADDRH(addrh_s), .ADDRV(addrv_s),
    .HS(hs_s), .VS(vs_s), .COLOUR_OUT(colo_s), .FRAME_TICK(ft_s)
  );

  vga_interface dut_b (
    .CLK(CLK), .RESET(RESET), .COLOUR_IN(col_b), .ADDRH(addrh_b), .ADDRV(addrv_b),
    .HS(hs_b), .VS(vs_b), .COLOUR_OUT(colo_b), .FRAME_TICK(ft_b)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: t = clocks since the last reset edge; the pixel being addressed is t/D.
  int         t = 0;
  bit         m_valid = 1'b0;
  int         mode = 0;
  logic       e_hs = 1'b1, e_vs = 1'b1;
  logic [7:0] e_col = 8'h00;
  int         ph, pv, pp;

  always @(posedge CLK) begin
    if (RESET) begin
      t = 0; e_hs = 1'b1; e_vs = 1'b1; e_col = 8'h00; m_valid = 1'b1;
    end else begin
      if (t % D == D - 1) begin
        pp = (t / D) % FR; ph = pp % HT; pv = pp / HT;
        e_hs = !(ph >= HA + HF && ph < HA + HF + HSY);
        e_vs = !(pv >= VA + VF && pv < VA + VF + VSY);
        if (ph < HA && pv < VA)
          e_col = (mode == 0) ? 8'(ph) : (mode == 1) ? 8'hFF : col_s;
        else
          e_col = 8'h00;
      end
      t++;
    end
  end

  // Colour sources: addressed-h game logic, constant white, or noise.
  always @(negedge CLK) begin
    if (!RESET && (t % (D * FR)) == 0) mode = $urandom_range(0, 2);
    case (mode)
      0:       col_s = addrh_s[7:0];
      1:       col_s = 8'hFF;
      default: col_s = 8'($urandom);
    endcase
    col_b = addrh_b[7:0];
  end

  int  ch, cv, cp;
  bit  cact, cft;
  always @(negedge CLK) begin
    if (m_valid) begin
      cp = (t / D) % FR; ch = cp % HT; cv = cp / HT;
      cact = (ch < HA) && (cv < VA);
      cft  = !RESET && (t % D == D - 1) && (cp == FR - 1);
      chk("addrh", 32'(addrh_s), cact ? 32'(ch) : 32'd0);
      chk("addrv", 32'(addrv_s), cact ? 32'(cv) : 32'd0);
      chk("hs", 32'(hs_s), 32'(e_hs));
      chk("vs", 32'(vs_s), 32'(e_vs));
      chk("colour", 32'(colo_s), 32'(e_col));
      chk("frame_tick", 32'(ft_s), 32'(cft));
    end
  end

  int n, cb, k, k1, k2, vs_low;
  int falls[$];
  int rises[$];
  logic hs_prev;

  initial begin
    RESET = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("rst_hs", 32'(hs_b), 32'd1);
    chk("rst_vs", 32'(vs_b), 32'd1);
    chk("rst_colour", 32'(colo_b), 32'd0);
    chk("rst_addrh", 32'(addrh_b), 32'd0);
    chk("rst_addrv", 32'(addrv_b), 32'd0);
    chk("rst_ft", 32'(ft_b), 32'd0);
    RESET = 1'b0;

    n = 0;
    while (addrh_b == 10'd0 && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    chk("first_addrh_clks", 32'(n), 32'd4);
    chk("first_addrh_val", 32'(addrh_b), 32'd1);

    // Full-size raster: three lines with literal timing expectations.
    cb = n;
    hs_prev = hs_b;
    while (cb < 3 * 3200 + 100) begin
      @(posedge CLK); #1; cb++;
      if (hs_b !== hs_prev) begin
        if (!hs_b) falls.push_back(cb);
        else       rises.push_back(cb);
      end
      hs_prev = hs_b;
      if (cb % 4 == 1)
        chk("big_addrh", 32'(addrh_b), ((cb / 4) % 800 < 640) ? 32'((cb / 4) % 800) : 32'd0);
      if (cb == 161) begin
        chk("colour_after_h39", 32'(colo_b), 32'h27);
        chk("addrh_40", 32'(addrh_b), 32'd40);
      end
      if (cb == 639 * 4 + 1) chk("addrh_639", 32'(addrh_b), 32'd639);
      if (cb == 640 * 4 + 1) chk("colour_after_h639", 32'(colo_b), 32'h7F);
      if (cb == 645 * 4 + 1) chk("blank_colour", 32'(colo_b), 32'h00);
      if (cb == 1700) chk("big_vs_idle", 32'(vs_b), 32'd1);
    end
    chk("hs_fall_count", 32'(falls.size() >= 2 && rises.size() >= 1), 32'd1);
    if (falls.size() >= 2 && rises.size() >= 1) begin
      chk("hs_first_fall", 32'(falls[0]), 32'd2628);
      chk("hs_low_width", 32'(rises[0] - falls[0]), 32'd384);
      chk("hs_period", 32'(falls[1] - falls[0]), 32'd3200);
    end

    // Mid-frame reset on the small raster at an active pixel.
    n = 0;
    while (!(((t / D) % FR) == 3 * HT + 10) && n < 2000) begin
      @(negedge CLK); n++;
    end
    chk("reach_midframe", 32'(n < 2000), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_hs", 32'(hs_b), 32'd1);
    chk("mid_rst_vs", 32'(vs_b), 32'd1);
    chk("mid_rst_colour", 32'(colo_s), 32'd0);
    chk("mid_rst_addrh", 32'(addrh_s), 32'd0);
    chk("mid_rst_addrv", 32'(addrv_s), 32'd0);
    chk("mid_rst_ft", 32'(ft_s), 32'd0);
    RESET = 1'b0;

    k = 0; k1 = -1; k2 = -1; vs_low = 0;
    while (k2 < 0 && k < 3000) begin
      @(negedge CLK); k++;
      if (k1 >= 0 && !vs_s) vs_low++;
      if (ft_s) begin
        if (k1 < 0) k1 = k;
        else        k2 = k;
      end
      if (k1 >= 0 && k == k1 + 1) chk("ft_width", 32'(ft_s), 32'd0);
    end
    chk("ft_found", 32'(k2 >= 0), 32'd1);
    chk("ft_first_after_reset", 32'(k1), 32'(D * FR - 1));
    chk("ft_interval", 32'(k2 - k1), 32'(D * FR));
    chk("vs_low_clks", 32'(vs_low), 32'(VSY * HT * D));

    repeat (6 * D * FR) @(posedge CLK);
    @(negedge CLK);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
